spi_rx_fifo: RTL and testbench

//  Parametrised SPI peripheral receiver, clocked entirely in the FPGA clk domain. It oversamples sck/sdi/cs,

---
 rtl/spi_rx_fifo.sv | 138 +++++++++++++
 tb/tb_spi_rx_fifo.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_rx_fifo.sv
// SPI peripheral receiver: oversampled sck/sdi/cs, WIDTH-bit deserialiser in any SPI mode,
// feeding a first-word-fall-through FIFO with a valid/ready read port.
module spi_rx_fifo #(
    parameter int WIDTH          = 8,
    parameter int DEPTH          = 4,
    parameter int CPOL           = 0,
    parameter int CPHA           = 0,
    parameter int CS_ACTIVE_HIGH = 1,
    parameter int MSB_FIRST      = 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       sck,
    input  logic                       sdi,
    input  logic                       cs,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       busy,
    output logic                       frame_err,
    output logic                       overflow,
    input  logic                       clr_ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int BW = $clog2(WIDTH);
    localparam logic SCK_IDLE    = (CPOL != 0);
    localparam logic CS_IDLE     = (CS_ACTIVE_HIGH == 0);
    localparam logic SAMPLE_RISE = ((CPOL != 0) == (CPHA != 0));
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH-1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic {IDLE, ACTIVE} state_t;

    logic sck_p0, sck_p1, sck_d;
    logic sdi_p0, sdi_p1;
    logic cs_p0, cs_p1;

    state_t           state;
    logic [BW-1:0]    bit_cnt;
    logic [WIDTH-2:0] shift_q;
    logic [WIDTH-1:0] shift_nxt;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic             sample_edge, cs_act, push, pop, full, wr_en;

    // ---- stage p0/p1: two-flop synchronisers, sck_d for edge detection ----
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sck_p0 <= SCK_IDLE;
            sck_p1 <= SCK_IDLE;
            sck_d  <= SCK_IDLE;
            sdi_p0 <= 1'b0;
            sdi_p1 <= 1'b0;
            cs_p0  <= CS_IDLE;
            cs_p1  <= CS_IDLE;
        end else begin
            sck_p0 <= sck;
            sck_p1 <= sck_p0;
            sck_d  <= sck_p1;
            sdi_p0 <= sdi;
            sdi_p1 <= sdi_p0;
            cs_p0  <= cs;
            cs_p1  <= cs_p0;
        end
    end

    assign sample_edge = SAMPLE_RISE ? (sck_p1 & ~sck_d) : (~sck_p1 & sck_d);
    assign cs_act      = cs_p1 ^ CS_IDLE;

    // Only the WIDTH-1 earlier bits are kept; the incoming bit completes the word.
    assign shift_nxt = (MSB_FIRST != 0) ? {shift_q, sdi_p1} : {sdi_p1, shift_q};

    // A release takes priority over a coincident sample edge.
    assign push = (state == ACTIVE) && cs_act && sample_edge && (bit_cnt == LAST_BIT);

    // ---- stage p2: frame FSM and deserialiser ----
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            frame_err <= 1'b0;
            bit_cnt   <= '0;
            shift_q   <= '0;
        end else begin
            frame_err <= 1'b0;
            if (state == IDLE) begin
                bit_cnt <= '0;
                if (cs_act) begin
                    state <= ACTIVE;
                    busy  <= 1'b1;
                end
            end else if (!cs_act) begin
                state     <= IDLE;
                busy      <= 1'b0;
                frame_err <= (bit_cnt != '0);
                bit_cnt   <= '0;
                shift_q   <= '0;
            end else if (sample_edge) begin
                shift_q <= (MSB_FIRST != 0) ? shift_nxt[WIDTH-2:0] : shift_nxt[WIDTH-1:1];
                bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + BW'(1);
            end
        end
    end

    assign full     = (count == FULL_CNT);
    assign rd_valid = (count != '0);
    assign pop      = rd_valid & rd_ready;
    // When full, a word is accepted only if the head leaves in the same cycle.
    assign wr_en    = push & (~full | pop);
    assign rd_data  = rd_valid ? mem[rptr] : '0;

    always_ff @(posedge clk) begin
        if (reset_n && wr_en)
            mem[wptr] <= shift_nxt;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en)
                wptr <= wptr + AW'(1);
            if (pop)
                rptr <= rptr + AW'(1);
            count <= count + CW'(wr_en) - CW'(pop);
            if (push && full && !pop)
                overflow <= 1'b1;
            else if (clr_ovf)
                overflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_spi_rx_fifo.sv
// Bench for spi_rx_fifo: eight instances cover every CPOL/CPHA/bit-order combination; instance 1
// (mode 0, MSB first) also gets directed FIFO tests and a randomized run against a queue model.
module tb_spi_rx_fifo;
    localparam int N    = 8;
    localparam int HALF = 4;
    localparam int MAIN = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset_n;
    logic [N-1:0] sck_v, sdi_v, cs_v, rd_ready_v, clr_ovf_v;
    logic [N-1:0] rd_valid_v, busy_v, ferr_v, ovf_v;
    logic [7:0]   rd_data_v [N];
    logic [2:0]   count_v [N];
    int           ferr_cnt [N];
    int           checks = 0;
    int           errors = 0;

    for (genvar g = 0; g < N; g++) begin : g_dut
        spi_rx_fifo #(
            .WIDTH(8), .DEPTH(4), .CPOL((g >> 2) & 1), .CPHA((g >> 1) & 1),
            .CS_ACTIVE_HIGH(1), .MSB_FIRST(g & 1)
        ) u_dut (
            .clk(clk), .reset_n(reset_n), .sck(sck_v[g]), .sdi(sdi_v[g]), .cs(cs_v[g]),
            .rd_data(rd_data_v[g]), .rd_valid(rd_valid_v[g]), .rd_ready(rd_ready_v[g]),
            .count(count_v[g]), .busy(busy_v[g]), .frame_err(ferr_v[g]),
            .overflow(ovf_v[g]), .clr_ovf(clr_ovf_v[g])
        );
    end

    always @(posedge clk) begin
        for (int i = 0; i < N; i++)
            if (ferr_v[i]) ferr_cnt[i] <= ferr_cnt[i] + 1;
    end

    function automatic logic cpol(int m); return m[2]; endfunction
    function automatic logic cpha(int m); return m[1]; endfunction
    function automatic logic msbf(int m); return m[0]; endfunction

    task automatic chk(string tag, int got, int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clks(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cs_on(int m);
        cs_v[m] = 1'b1;
        clks(4);
    endtask

    task automatic cs_off(int m);
        cs_v[m] = 1'b0;
        clks(6);
    endtask

    // hook 1: check FWFT latency around the last sample edge; hook 2: pop in the push cycle
    task automatic last_edge(int m, int hook, logic [7:0] w);
        @(posedge clk);
        @(negedge clk);
        @(posedge clk); #1;
        if (hook == 1) chk("lat_n1_valid", int'(rd_valid_v[m]), 0);
        @(negedge clk);
        if (hook == 2) rd_ready_v[m] = 1'b1;
        @(posedge clk); #1;
        if (hook == 1) begin
            chk("lat_n2_valid", int'(rd_valid_v[m]), 1);
            chk("lat_n2_data", int'(rd_data_v[m]), int'(w));
        end
        @(negedge clk);
        rd_ready_v[m] = 1'b0;
        clks(HALF - 3);
    endtask

    task automatic spi_bits(int m, logic [31:0] w, int n, int hook);
        for (int i = 0; i < n; i++) begin
            logic b;
            b = msbf(m) ? w[n-1-i] : w[i];
            if (!cpha(m)) begin
                sdi_v[m] = b;
                clks(HALF);
                sck_v[m] = ~cpol(m);
                if (hook != 0 && i == n-1) last_edge(m, hook, w[7:0]);
                else clks(HALF);
                sck_v[m] = cpol(m);
                clks(HALF);
            end else begin
                sck_v[m] = ~cpol(m);
                sdi_v[m] = b;
                clks(HALF);
                sck_v[m] = cpol(m);
                if (hook != 0 && i == n-1) last_edge(m, hook, w[7:0]);
                else clks(HALF);
            end
        end
    endtask

    task automatic send_word(int m, logic [7:0] w);
        spi_bits(m, 32'(w), 8, 0);
    endtask

    task automatic pop_chk(int m, logic [7:0] exp, string tag);
        chk("pop_valid", int'(rd_valid_v[m]), 1);
        chk(tag, int'(rd_data_v[m]), int'(exp));
        rd_ready_v[m] = 1'b1;
        clks(1);
        rd_ready_v[m] = 1'b0;
    endtask

    initial begin
        logic [7:0] q [$];
        bit         ovf_m;
        int         f0;

        reset_n    = 1'b0;
        cs_v       = '0;
        sdi_v      = '0;
        rd_ready_v = '0;
        clr_ovf_v  = '0;
        for (int m = 0; m < N; m++) sck_v[m] = cpol(m);
        clks(3);
        chk("rst_count", int'(count_v[MAIN]), 0);
        chk("rst_valid", int'(rd_valid_v[MAIN]), 0);
        chk("rst_data", int'(rd_data_v[MAIN]), 0);
        chk("rst_busy", int'(busy_v[MAIN]), 0);
        chk("rst_ovf", int'(ovf_v[MAIN]), 0);
        chk("rst_ferr", int'(ferr_v[MAIN]), 0);
        reset_n = 1'b1;
        clks(3);

        // T1: single word, latency and FWFT head
        cs_on(MAIN);
        chk("t1_busy", int'(busy_v[MAIN]), 1);
        spi_bits(MAIN, 32'hA5, 8, 1);
        chk("t1_count", int'(count_v[MAIN]), 1);
        cs_off(MAIN);
        chk("t1_idle", int'(busy_v[MAIN]), 0);
        pop_chk(MAIN, 8'hA5, "t1_pop");

        // T2: three words in one frame
        f0 = ferr_cnt[MAIN];
        cs_on(MAIN);
        send_word(MAIN, 8'h01);
        send_word(MAIN, 8'h02);
        send_word(MAIN, 8'h03);
        cs_off(MAIN);
        chk("t2_count3", int'(count_v[MAIN]), 3);
        pop_chk(MAIN, 8'h01, "t2_pop1");
        pop_chk(MAIN, 8'h02, "t2_pop2");
        pop_chk(MAIN, 8'h03, "t2_pop3");
        chk("t2_count0", int'(count_v[MAIN]), 0);
        chk("t2_ferr", ferr_cnt[MAIN] - f0, 0);

        // T3: overflow on the fifth word, then clear
        cs_on(MAIN);
        for (int i = 0; i < 5; i++) send_word(MAIN, 8'(8'h10 + i));
        cs_off(MAIN);
        chk("t3_count", int'(count_v[MAIN]), 4);
        chk("t3_ovf", int'(ovf_v[MAIN]), 1);
        chk("t3_head", int'(rd_data_v[MAIN]), 8'h10);
        clr_ovf_v[MAIN] = 1'b1;
        clks(1);
        clr_ovf_v[MAIN] = 1'b0;
        chk("t3_clr", int'(ovf_v[MAIN]), 0);

        // T4: full FIFO, pop in the same cycle as the push
        cs_on(MAIN);
        spi_bits(MAIN, 32'h14, 8, 2);
        cs_off(MAIN);
        chk("t4_count", int'(count_v[MAIN]), 4);
        chk("t4_ovf", int'(ovf_v[MAIN]), 0);
        for (int i = 1; i < 5; i++) pop_chk(MAIN, 8'(8'h10 + i), "t4_pop");
        chk("t4_empty", int'(count_v[MAIN]), 0);

        // T5: short frame, then a good word
        f0 = ferr_cnt[MAIN];
        cs_on(MAIN);
        spi_bits(MAIN, 32'h16, 5, 0);
        cs_off(MAIN);
        chk("t5_ferr", ferr_cnt[MAIN] - f0, 1);
        chk("t5_count", int'(count_v[MAIN]), 0);
        cs_on(MAIN);
        send_word(MAIN, 8'h3C);
        cs_off(MAIN);
        chk("t5_ferr_after", ferr_cnt[MAIN] - f0, 1);
        pop_chk(MAIN, 8'h3C, "t5_pop");

        // T6: all SPI modes and both bit orders
        for (int m = 0; m < N; m++) begin
            cs_on(m);
            send_word(m, 8'hC3);
            send_word(m, 8'h1E);
            cs_off(m);
            chk("t6_count", int'(count_v[m]), 2);
            pop_chk(m, 8'hC3, "t6_c3");
            pop_chk(m, 8'h1E, "t6_1e");
        end

        // Randomized frames against a queue model
        ovf_m = 1'b0;
        for (int r = 0; r < 14; r++) begin
            int k, part, j;
            k    = $urandom_range(1, 6);
            part = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
            f0   = ferr_cnt[MAIN];
            cs_on(MAIN);
            for (int i = 0; i < k; i++) begin
                logic [7:0] w;
                w = 8'($urandom);
                send_word(MAIN, w);
                if (q.size() < 4) q.push_back(w);
                else ovf_m = 1'b1;
            end
            if (part != 0) spi_bits(MAIN, $urandom, part, 0);
            cs_off(MAIN);
            chk("rnd_count", int'(count_v[MAIN]), q.size());
            chk("rnd_ovf", int'(ovf_v[MAIN]), int'(ovf_m));
            chk("rnd_ferr", ferr_cnt[MAIN] - f0, (part != 0) ? 1 : 0);
            if (ovf_m && $urandom_range(0, 1) == 1) begin
                clr_ovf_v[MAIN] = 1'b1;
                clks(1);
                clr_ovf_v[MAIN] = 1'b0;
                ovf_m = 1'b0;
                chk("rnd_clr", int'(ovf_v[MAIN]), 0);
            end
            j = $urandom_range(0, q.size());
            for (int i = 0; i < j; i++) pop_chk(MAIN, q.pop_front(), "rnd_pop");
        end

        // Reset in the middle of a word
        f0 = ferr_cnt[MAIN];
        cs_on(MAIN);
        send_word(MAIN, 8'h77);
        spi_bits(MAIN, 32'h5, 3, 0);
        reset_n = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_count", int'(count_v[MAIN]), 0);
        chk("mid_rst_valid", int'(rd_valid_v[MAIN]), 0);
        chk("mid_rst_busy", int'(busy_v[MAIN]), 0);
        chk("mid_rst_ovf", int'(ovf_v[MAIN]), 0);
        @(negedge clk);
        reset_n = 1'b1;
        clks(6);
        chk("mid_rst_rebusy", int'(busy_v[MAIN]), 1);
        cs_off(MAIN);
        chk("mid_rst_ferr", ferr_cnt[MAIN] - f0, 0);
        chk("mid_rst_count2", int'(count_v[MAIN]), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
